// File: rtl/chip8_mem_arbiter.sv
// Arbitrates the shared Chip8 4096x8 dual-port memory between the host load path,
// CPU instruction fetch (two bytes per access) and CPU data accesses.
module chip8_mem_arbiter #(
  parameter int HOST_BURST_MAX = 4,
  parameter int ADDR_W         = 12
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [7:0]        host_rdata,

  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [15:0]       fetch_instr,

  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [7:0]        data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [7:0]        data_rdata,

  output logic [ADDR_W-1:0] mem_addr1,
  output logic [ADDR_W-1:0] mem_addr2,
  output logic [7:0]        mem_wdata1,
  output logic [7:0]        mem_wdata2,
  output logic              mem_we1,
  output logic              mem_we2,
  input  logic [7:0]        mem_rdata1,
  input  logic [7:0]        mem_rdata2
);

  localparam int              RUN_W   = 4;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(HOST_BURST_MAX);

  typedef enum logic {PRIO_FETCH, PRIO_DATA} prio_e;

  prio_e             prio_q, prio_d;
  logic [RUN_W-1:0]  host_run_q, host_run_d;
  logic              host_rv_q, host_rv_d;
  logic              fetch_rv_q, fetch_rv_d;
  logic              data_rv_q, data_rv_d;
  logic [7:0]        host_rdata_q, host_rdata_d;
  logic [7:0]        data_rdata_q, data_rdata_d;
  logic [15:0]       fetch_instr_q, fetch_instr_d;
  logic [ADDR_W-1:0] fetch_addr_nxt;
  logic              cpu_req;

  assign fetch_addr_nxt = fetch_addr + ADDR_W'(1);
  assign cpu_req        = fetch_req | data_req;

  // Grants are suppressed while reset is held so no access reaches the macro.
  always_comb begin
    host_gnt  = 1'b0;
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (reset) begin
      if (host_req && (host_lock || !((host_run_q == RUN_MAX) && cpu_req))) begin
        host_gnt = 1'b1;
      end else if (!host_lock) begin
        if (fetch_req && (!data_req || (prio_q == PRIO_FETCH))) begin
          fetch_gnt = 1'b1;
        end else if (data_req) begin
          data_gnt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (fetch_gnt) begin
      prio_d = PRIO_DATA;
    end else if (data_gnt) begin
      prio_d = PRIO_FETCH;
    end

    host_run_d = '0;
    if (host_gnt) begin
      host_run_d = (host_run_q == RUN_MAX) ? RUN_MAX : host_run_q + RUN_W'(1);
    end

    host_rv_d  = host_gnt & ~host_we;
    fetch_rv_d = fetch_gnt;
    data_rv_d  = data_gnt & ~data_we;

    // Read data is passed straight through during the valid cycle, then held.
    host_rdata_d  = host_rv_q  ? mem_rdata1 : host_rdata_q;
    data_rdata_d  = data_rv_q  ? mem_rdata1 : data_rdata_q;
    fetch_instr_d = fetch_rv_q ? {mem_rdata1, mem_rdata2} : fetch_instr_q;
  end

  always_comb begin
    mem_addr1  = fetch_addr;
    mem_addr2  = fetch_addr_nxt;
    mem_wdata1 = '0;
    mem_we1    = 1'b0;
    if (host_gnt) begin
      mem_addr1  = host_addr;
      mem_wdata1 = host_wdata;
      mem_we1    = host_we;
    end else if (data_gnt) begin
      mem_addr1  = data_addr;
      mem_wdata1 = data_wdata;
      mem_we1    = data_we;
    end
  end

  assign mem_wdata2 = '0;
  assign mem_we2    = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q        <= PRIO_FETCH;
      host_run_q    <= '0;
      host_rv_q     <= 1'b0;
      fetch_rv_q    <= 1'b0;
      data_rv_q     <= 1'b0;
      host_rdata_q  <= '0;
      data_rdata_q  <= '0;
      fetch_instr_q <= '0;
    end else begin
      prio_q        <= prio_d;
      host_run_q    <= host_run_d;
      host_rv_q     <= host_rv_d;
      fetch_rv_q    <= fetch_rv_d;
      data_rv_q     <= data_rv_d;
      host_rdata_q  <= host_rdata_d;
      data_rdata_q  <= data_rdata_d;
      fetch_instr_q <= fetch_instr_d;
    end
  end

  assign host_rvalid  = host_rv_q;
  assign fetch_rvalid = fetch_rv_q;
  assign data_rvalid  = data_rv_q;
  assign host_rdata   = host_rdata_d;
  assign data_rdata   = data_rdata_d;
  assign fetch_instr  = fetch_instr_d;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Self-checking bench for chip8_mem_arbiter: a behavioural memory macro plus a
// reference memory image and rule-level arbitration model kept in the bench.
module tb_chip8_mem_arbiter;

  localparam int HB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_req, host_we, host_lock;
  logic [11:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_gnt, host_rvalid;
  logic [7:0]  host_rdata;
  logic        fetch_req;
  logic [11:0] fetch_addr;
  logic        fetch_gnt, fetch_rvalid;
  logic [15:0] fetch_instr;
  logic        data_req, data_we;
  logic [11:0] data_addr;
  logic [7:0]  data_wdata;
  logic        data_gnt, data_rvalid;
  logic [7:0]  data_rdata;
  logic [11:0] mem_addr1, mem_addr2;
  logic [7:0]  mem_wdata1, mem_wdata2;
  logic        mem_we1, mem_we2;
  logic [7:0]  mem_rdata1, mem_rdata2;

  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic        we2_seen = 1'b0;

  int          n_cmp = 0;
  int          n_err = 0;
  int          last_cpu;
  logic [7:0]  held_hr, held_dr;
  logic [15:0] held_fi;

  chip8_mem_arbiter #(.HOST_BURST_MAX(HB), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_instr(fetch_instr),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_wdata1(mem_wdata1), .mem_wdata2(mem_wdata2),
    .mem_we1(mem_we1), .mem_we2(mem_we2),
    .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2)
  );

  always #5 clk = ~clk;

  // Dual-port memory macro with a one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we1) mem[mem_addr1] <= mem_wdata1;
    mem_rdata1 <= mem[mem_addr1];
    mem_rdata2 <= mem[mem_addr2];
    if (mem_we2) we2_seen <= 1'b1;
  end

  task automatic host_write(input logic [11:0] a, input logic [7:0] d);
    int k;
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    #1;
    k = 0;
    while (!host_gnt && k < 20) begin
      @(posedge clk); #2;
      k++;
    end
    if (!host_gnt) begin
      n_cmp++; n_err++;
      $display("[TB] FAIL host_write_timeout: addr %h never granted, required grant within 20 cycles", a);
    end else begin
      ref_mem[a] = d;
    end
    @(posedge clk); #1;
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic test_reset();
    host_req = 1'b1; fetch_req = 1'b1; data_req = 1'b1; host_we = 1'b1;
    #2;
    n_cmp++;
    if ({host_gnt, fetch_gnt, data_gnt} !== 3'b000) begin
      n_err++; $display("[TB] FAIL reset_gnt: got %b required 000", {host_gnt, fetch_gnt, data_gnt});
    end
    n_cmp++;
    if ({host_rvalid, fetch_rvalid, data_rvalid, mem_we1} !== 4'b0000) begin
      n_err++; $display("[TB] FAIL reset_rvalid_we: got %b required 0000", {host_rvalid, fetch_rvalid, data_rvalid, mem_we1});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({host_rdata, data_rdata, fetch_instr} !== 32'h0) begin
      n_err++; $display("[TB] FAIL reset_rdata: got %h required 00000000", {host_rdata, data_rdata, fetch_instr});
    end
    host_req = 1'b0; fetch_req = 1'b0; data_req = 1'b0; host_we = 1'b0;
    reset = 1'b1;
    last_cpu = 1;
    held_hr = 8'h0; held_dr = 8'h0; held_fi = 16'h0;
    @(posedge clk); #1;
  endtask

  task automatic preload();
    for (int a = 0; a < 64; a++) begin
      host_write(12'(a), 8'($urandom));
      host_write(12'(12'h200 + a), 8'($urandom));
    end
  endtask

  task automatic test_fetch(input logic [11:0] fa, input logic [7:0] hi, input logic [7:0] lo,
                            input logic [11:0] exp_a2);
    host_write(fa, hi);
    host_write(12'(fa + 12'd1), lo);
    fetch_req = 1'b1; fetch_addr = fa;
    #1;
    n_cmp++;
    if ({host_gnt, fetch_gnt, data_gnt} !== 3'b010) begin
      n_err++; $display("[TB] FAIL fetch_gnt: got %b required 010", {host_gnt, fetch_gnt, data_gnt});
    end
    n_cmp++;
    if ({mem_addr1, mem_addr2, mem_we1} !== {fa, exp_a2, 1'b0}) begin
      n_err++; $display("[TB] FAIL fetch_mem_addr: got %h/%h we %b required %h/%h we 0", mem_addr1, mem_addr2, mem_we1, fa, exp_a2);
    end
    last_cpu = 0;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    n_cmp++;
    if (fetch_rvalid !== 1'b1 || fetch_instr !== {hi, lo}) begin
      n_err++; $display("[TB] FAIL fetch_instr: got v=%b %h required v=1 %h", fetch_rvalid, fetch_instr, {hi, lo});
    end
    held_fi = {hi, lo};
    @(posedge clk); #1;
    n_cmp++;
    if (fetch_rvalid !== 1'b0 || fetch_instr !== held_fi) begin
      n_err++; $display("[TB] FAIL fetch_hold: got v=%b %h required v=0 %h", fetch_rvalid, fetch_instr, held_fi);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  eg;
    logic        efv, edv;
    logic [15:0] efi;
    logic [7:0]  edr;
    fetch_req = 1'b1; data_req = 1'b1;
    fetch_addr = 12'(12'h200 + 12'($urandom_range(0, 62)));
    data_addr = 12'($urandom_range(0, 63));
    data_we = 1'($urandom); data_wdata = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      #1;
      eg = (last_cpu == 0) ? 3'b001 : 3'b010;
      n_cmp++;
      if ({host_gnt, fetch_gnt, data_gnt} !== eg) begin
        n_err++; $display("[TB] FAIL rr_gnt[%0d]: got %b required %b", i, {host_gnt, fetch_gnt, data_gnt}, eg);
      end
      efv = 1'b0; edv = 1'b0; efi = 16'h0; edr = 8'h0;
      if (eg[1]) begin
        last_cpu = 0; efv = 1'b1;
        efi = {ref_mem[fetch_addr], ref_mem[12'(fetch_addr + 12'd1)]};
      end
      if (eg[0]) begin
        last_cpu = 1;
        if (data_we) ref_mem[data_addr] = data_wdata;
        else begin edv = 1'b1; edr = ref_mem[data_addr]; end
      end
      @(posedge clk); #1;
      if (efv) held_fi = efi;
      if (edv) held_dr = edr;
      n_cmp++;
      if (fetch_rvalid !== efv || fetch_instr !== held_fi) begin
        n_err++; $display("[TB] FAIL rr_fetch[%0d]: got v=%b %h required v=%b %h", i, fetch_rvalid, fetch_instr, efv, held_fi);
      end
      n_cmp++;
      if (data_rvalid !== edv || data_rdata !== held_dr) begin
        n_err++; $display("[TB] FAIL rr_data[%0d]: got v=%b %h required v=%b %h", i, data_rvalid, data_rdata, edv, held_dr);
      end
      if (eg[1]) fetch_addr = 12'(12'h200 + 12'($urandom_range(0, 62)));
      if (eg[0]) begin
        data_addr = 12'($urandom_range(0, 63));
        data_we = 1'($urandom); data_wdata = 8'($urandom);
      end
    end
    fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
  endtask

  task automatic test_host_burst();
    int         run;
    int         dcount;
    logic [2:0] eg;
    logic       ehv, edv;
    logic [7:0] ehr, edr;
    run = 0; dcount = 0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 12'($urandom_range(0, 63));
    host_we = 1'($urandom); host_addr = 12'($urandom_range(0, 63)); host_wdata = 8'($urandom);
    for (int i = 0; i < 36; i++) begin
      host_lock = (i >= 20 && i < 32);
      host_req = (i < 30);
      #1;
      if (host_req && (host_lock || !(run == HB && (fetch_req || data_req)))) eg = 3'b100;
      else if (!host_lock && data_req) eg = 3'b001;
      else eg = 3'b000;
      n_cmp++;
      if ({host_gnt, fetch_gnt, data_gnt} !== eg) begin
        n_err++; $display("[TB] FAIL burst_gnt[%0d]: got %b required %b", i, {host_gnt, fetch_gnt, data_gnt}, eg);
      end
      if (i < 10 && data_gnt) dcount++;
      ehv = 1'b0; edv = 1'b0; ehr = 8'h0; edr = 8'h0;
      if (eg[2]) begin
        run = (run < HB) ? run + 1 : HB;
        if (host_we) ref_mem[host_addr] = host_wdata;
        else begin ehv = 1'b1; ehr = ref_mem[host_addr]; end
      end else begin
        run = 0;
      end
      if (eg[0]) begin
        last_cpu = 1; edv = 1'b1; edr = ref_mem[data_addr];
      end
      @(posedge clk); #1;
      if (ehv) held_hr = ehr;
      if (edv) held_dr = edr;
      n_cmp++;
      if (host_rvalid !== ehv || host_rdata !== held_hr) begin
        n_err++; $display("[TB] FAIL burst_host_rd[%0d]: got v=%b %h required v=%b %h", i, host_rvalid, host_rdata, ehv, held_hr);
      end
      n_cmp++;
      if (data_rvalid !== edv || data_rdata !== held_dr) begin
        n_err++; $display("[TB] FAIL burst_data_rd[%0d]: got v=%b %h required v=%b %h", i, data_rvalid, data_rdata, edv, held_dr);
      end
      if (eg[2]) begin
        host_we = 1'($urandom); host_addr = 12'($urandom_range(0, 63)); host_wdata = 8'($urandom);
      end
      if (eg[0]) data_addr = 12'($urandom_range(0, 63));
    end
    data_req = 1'b0; host_req = 1'b0; host_lock = 1'b0; host_we = 1'b0;
    n_cmp++;
    if (dcount !== 2) begin
      n_err++; $display("[TB] FAIL burst_data_count: got %0d data grants in 10 cycles required 2", dcount);
    end
  endtask

  task automatic test_host_read();
    host_write(12'h050, 8'hF0);
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h050;
    #1;
    n_cmp++;
    if ({host_gnt, fetch_gnt, data_gnt} !== 3'b100) begin
      n_err++; $display("[TB] FAIL hread_gnt: got %b required 100", {host_gnt, fetch_gnt, data_gnt});
    end
    @(posedge clk); #1;
    host_req = 1'b0;
    n_cmp++;
    if ({host_rvalid, data_rvalid, fetch_rvalid} !== 3'b100 || host_rdata !== 8'hF0) begin
      n_err++; $display("[TB] FAIL hread_data: got v=%b %h required v=100 f0", {host_rvalid, data_rvalid, fetch_rvalid}, host_rdata);
    end
    held_hr = 8'hF0;
    @(posedge clk); #1;
    n_cmp++;
    if (host_rvalid !== 1'b0 || host_rdata !== 8'hF0) begin
      n_err++; $display("[TB] FAIL hread_hold: got v=%b %h required v=0 f0", host_rvalid, host_rdata);
    end
  endtask

  task automatic test_reset_midop();
    data_req = 1'b1; data_we = 1'b0; data_addr = 12'h050;
    #1;
    n_cmp++;
    if (data_gnt !== 1'b1) begin
      n_err++; $display("[TB] FAIL rmid_gnt: got %b required 1", data_gnt);
    end
    @(posedge clk); #1;
    data_req = 1'b0;
    n_cmp++;
    if (data_rvalid !== 1'b1 || data_rdata !== 8'hF0) begin
      n_err++; $display("[TB] FAIL rmid_pre: got v=%b %h required v=1 f0", data_rvalid, data_rdata);
    end
    #1;
    reset = 1'b0;
    host_req = 1'b1; host_we = 1'b1; fetch_req = 1'b1; data_req = 1'b1;
    #1;
    n_cmp++;
    if ({host_rvalid, fetch_rvalid, data_rvalid, host_gnt, fetch_gnt, data_gnt, mem_we1} !== 7'b0) begin
      n_err++; $display("[TB] FAIL rmid_ctrl: got %b required 0000000",
                        {host_rvalid, fetch_rvalid, data_rvalid, host_gnt, fetch_gnt, data_gnt, mem_we1});
    end
    n_cmp++;
    if ({host_rdata, data_rdata, fetch_instr} !== 32'h0) begin
      n_err++; $display("[TB] FAIL rmid_rdata: got %h required 00000000", {host_rdata, data_rdata, fetch_instr});
    end
    host_req = 1'b0; host_we = 1'b0; fetch_req = 1'b0; data_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    last_cpu = 1;
    held_hr = 8'h0; held_dr = 8'h0; held_fi = 16'h0;
    @(posedge clk); #1;
    n_cmp++;
    if ({host_rvalid, fetch_rvalid, data_rvalid} !== 3'b000) begin
      n_err++; $display("[TB] FAIL rmid_stray: got %b required 000", {host_rvalid, fetch_rvalid, data_rvalid});
    end
    fetch_req = 1'b1; fetch_addr = 12'h200; data_req = 1'b1; data_addr = 12'h050;
    #1;
    n_cmp++;
    if ({fetch_gnt, data_gnt} !== 2'b10) begin
      n_err++; $display("[TB] FAIL rmid_prio: got %b required 10", {fetch_gnt, data_gnt});
    end
    @(posedge clk); #1;
    fetch_req = 1'b0;
    #1;
    n_cmp++;
    if ({fetch_gnt, data_gnt} !== 2'b01) begin
      n_err++; $display("[TB] FAIL rmid_prio2: got %b required 01", {fetch_gnt, data_gnt});
    end
    @(posedge clk); #1;
    data_req = 1'b0;
    n_cmp++;
    if (data_rvalid !== 1'b1 || data_rdata !== ref_mem[12'h050]) begin
      n_err++; $display("[TB] FAIL rmid_post_rd: got v=%b %h required v=1 %h", data_rvalid, data_rdata, ref_mem[12'h050]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 12'h0; host_wdata = 8'h0; host_lock = 1'b0;
    fetch_req = 1'b0; fetch_addr = 12'h0;
    data_req = 1'b0; data_we = 1'b0; data_addr = 12'h0; data_wdata = 8'h0;
    test_reset();
    preload();
    test_fetch(12'h200, 8'hA2, 8'h1E, 12'h201);
    test_fetch(12'hFFF, 8'h12, 8'h34, 12'h000);
    test_round_robin();
    test_host_burst();
    test_host_read();
    test_reset_midop();
    n_cmp++;
    if (we2_seen !== 1'b0) begin
      n_err++; $display("[TB] FAIL mem_we2: got %b required 0", we2_seen);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chip8_mem_arbiter.md
Name: chip8_mem_arbiter

Overview:
- Shares the Chip8 4096x8 dual-port program/data memory between three requesters:
  - host: ARM/Avalon load and debug path
  - CPU instruction fetch: 16-bit, two bytes
  - CPU data access: Fx55/Fx65, Dxyn sprite reads, BCD writes
- Sits between the top-level controller/CPU and the memory macro.
- Drives both memory ports and returns read data with a fixed 1-cycle latency.

Parameters:
- HOST_BURST_MAX, 4: max consecutive host grants before one cycle is yielded to a waiting CPU requester (range 1-15).
- ADDR_W, 12: memory address width; all address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- host_req  in  1  host access request
- host_we  in  1  1=write, 0=read
- host_addr  in  12  host byte address
- host_wdata  in  8  host write byte
- host_lock  in  1  1=CPU requesters never granted (program loading)
- host_gnt  out  1  host granted this cycle (combinational)
- host_rvalid  out  1  host read data valid
- host_rdata  out  8  host read byte
- fetch_req  in  1  instruction fetch request
- fetch_addr  in  12  address of high byte
- fetch_gnt  out  1  fetch granted (combinational)
- fetch_rvalid  out  1  instruction valid
- fetch_instr  out  16  {mem[addr], mem[addr+1]}
- data_req  in  1  CPU data request
- data_we  in  1  1=write
- data_addr  in  12  CPU data byte address
- data_wdata  in  8  CPU write byte
- data_gnt  out  1  data granted (combinational)
- data_rvalid  out  1  data read valid
- data_rdata  out  8  data read byte
- mem_addr1, mem_addr2  out  12  memory port addresses
- mem_wdata1, mem_wdata2  out  8  memory write data
- mem_we1, mem_we2  out  1  memory write enables
- mem_rdata1, mem_rdata2  in  8  memory read data (valid 1 cycle after address)

Behaviour:
- Reset (reset=0, async):
  - all *_gnt forced 0; all *_rvalid 0; host_rdata, data_rdata, fetch_instr 0
  - round-robin pointer favours fetch; host run counter 0
- Requester protocol:
  - Requester holds req, addr, we and wdata stable until gnt.
  - Exactly one access per gnt cycle; req may stay high for back-to-back accesses.
  - At most one gnt is high per cycle.
- Arbitration, evaluated each cycle:
  - host_lock=1: only host may be granted.
  - Otherwise host wins, unless host_run==HOST_BURST_MAX and fetch_req|data_req. In that case the host is denied for that one cycle and the CPU winner is granted.
  - Fetch vs data, with no host grant: round robin. Both requesting → the one not granted most recently wins. A single requester always wins.
- Host run counter:
  - increments on each host grant, saturating at HOST_BURST_MAX
  - clears on any cycle without a host grant
- Memory drive, combinational from the winner:
  - host / data: port1 = addr, wdata, we; port2 idle (we2=0)
  - fetch: port1 = fetch_addr, port2 = fetch_addr+1 mod 4096 (0xFFF → 0x000); both we=0
  - idle: mem_addr1=fetch_addr, mem_addr2=fetch_addr+1, both we=0
  - mem_we2 is never asserted by this block.
- Read return:
  - A granted read in cycle N asserts the matching *_rvalid for exactly cycle N+1.
  - Data is registered from mem_rdata at the end of cycle N+1 and held until the next rvalid for that requester.
  - Writes produce no rvalid.
  - Odd fetch addresses are legal.
- Back-to-back: a grant in cycle N+1 is independent of the rvalid in N+1; full throughput is 1 access/cycle.
- Reset mid-operation: a pending rvalid is cancelled; no rvalid is issued after reset is released for accesses granted before reset.
- host_lock rising while a CPU request waits: the CPU request stays ungranted and must keep req high; no timeout.

Test Plan:
- Reset, then host writes 0xA2 to 0x200 and 0x1E to 0x201; fetch_req at 0x200 → fetch_gnt same cycle; fetch_rvalid next cycle with fetch_instr=0xA21E.
- Fetch at 0xFFF with mem[0xFFF]=0x12, mem[0x000]=0x34 → mem_addr2=0x000; fetch_instr=0x1234.
- fetch_req and data_req held high continuously, no host → grants alternate fetch, data, fetch, data…; each rvalid one cycle after its grant.
- host_req held high with host_lock=0, HOST_BURST_MAX=4, data_req high → 4 host grants, 1 data grant, then 4 host grants; with host_lock=1 → data is never granted.
- Host read of 0x050 (preloaded 0xF0) granted in cycle N → host_rvalid=1 only in N+1 with host_rdata=0xF0; data_rvalid and fetch_rvalid stay 0.
- Data read granted, then reset asserted in cycle N+1 before the clock edge → data_rvalid=0 immediately; all outputs at reset values; no stray rvalid after release.
